// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//   Multi-cycle sequencer that produces an unsigned multiply (MULTU) and,
//   when ALU_SEQ_DIV_EN is defined, an unsigned restoring divide (DIVU).
//   It works by stepping the shared combinational ALU adder once per clock.
//   While busy, it owns the ALU operand inputs. It keeps the HI/LO result
//   pair until the next accepted start.
//
//   Build option:
//     ALU_SEQ_DIV_EN  defined   -> op=1 selects DIVU
//                     undefined -> op is ignored, every start runs MULTU,
//                                  and alu_cin/alu_c2 stay 0
//
//   Parameter:
//     bus       operand width; HI and LO are each bus bits (bus >= 2)
//
//   Ports:
//     clk       rising-edge clock
//     rst       synchronous active-high reset
//     start     request; sampled only in IDLE
//     op        0=MULTU, 1=DIVU
//     opa, opb  multiplicand/dividend, multiplier/divisor
//     alu_a, alu_b, alu_cin, alu_c2   drive the ALU
//     alu_sout, alu_cout              ALU result, same cycle
//     busy      high in every iteration cycle
//     done      one-cycle completion pulse
//     hi, lo    product high/low half, or remainder/quotient
//     res_zero  high when {hi,lo} == 0
// ---------------------------------------------------------------------------
module alu_seq_ctrl #(
   parameter int bus = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           op,
   input  logic [bus-1:0] opa,
   input  logic [bus-1:0] opb,
   output logic [bus-1:0] alu_a,
   output logic [bus-1:0] alu_b,
   output logic           alu_cin,
   output logic           alu_c2,
   input  logic [bus-1:0] alu_sout,
   input  logic           alu_cout,
   output logic           busy,
   output logic           done,
   output logic [bus-1:0] hi,
   output logic [bus-1:0] lo,
   output logic           res_zero
);

   localparam int CW = $clog2(bus + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state, state_next;
   logic [CW-1:0]  cnt;
   logic [bus-1:0] m;

`ifdef ALU_SEQ_DIV_EN
   logic           op_r;
   logic           div_ok;
`else
   // The MULTU-only build has no use for op. Keeping the port unchanged
   // leaves this sink behind on purpose.
   logic           unused_op;
   assign unused_op = op;
`endif

   // State register
   always_ff @(posedge clk) begin
      // NOTE: use non-blocking assignments for every registered signal, so
      // all of them update together at the edge and see pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next state plus ALU drive
   always_comb begin
      // NOTE: every output gets its default first. That way no branch
      // leaves a value unassigned and infers a latch.
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      alu_a      = '0;
      alu_b      = '0;
      alu_cin    = 1'b0;
      alu_c2     = 1'b0;
`ifdef ALU_SEQ_DIV_EN
      div_ok     = 1'b0;
`endif
      case (state)
         IDLE: if (start) state_next = RUN;
         RUN: begin
            busy = 1'b1;
            if (cnt == CW'(1)) state_next = DONE;
`ifdef ALU_SEQ_DIV_EN
            if (op_r) begin
               // Trial subtract: (remainder shifted in with the next dividend bit) - M.
               alu_a   = {hi[bus-2:0], lo[bus-1]};
               alu_b   = m;
               alu_cin = 1'b1;
               alu_c2  = 1'b1;
               // The bit shifted out of hi is the implicit 9th bit of the
               // partial remainder. If it is set, the subtract always fits.
               div_ok  = hi[bus-1] | alu_cout;
            end else begin
               alu_a = hi;
               alu_b = lo[0] ? m : '0;
            end
`else
            alu_a = hi;
            alu_b = lo[0] ? m : '0;
`endif
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: counter, operand latch, and the HI/LO shift pair
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         hi   <= '0;
         lo   <= '0;
         m    <= '0;
`ifdef ALU_SEQ_DIV_EN
         op_r <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               cnt  <= CW'(bus);
               hi   <= '0;
               lo   <= opa;
               m    <= opb;
`ifdef ALU_SEQ_DIV_EN
               op_r <= op;
`endif
            end
            RUN: begin
               cnt <= cnt - 1'b1;
`ifdef ALU_SEQ_DIV_EN
               if (op_r) begin
                  hi <= div_ok ? alu_sout : alu_a;
                  lo <= {lo[bus-2:0], div_ok};
               end else begin
                  hi <= {alu_cout, alu_sout[bus-1:1]};
                  lo <= {alu_sout[0], lo[bus-1:1]};
               end
`else
               // Shift-add: the sum shifts right into hi, and its LSB
               // becomes the next product bit at the top of lo.
               hi <= {alu_cout, alu_sout[bus-1:1]};
               lo <= {alu_sout[0], lo[bus-1:1]};
`endif
            end
            default: ;
         endcase
      end
   end

   assign res_zero = (hi == '0) && (lo == '0);

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer that computes unsigned multiply (MULTU), and optionally unsigned divide (DIVU), by iterating the shared ALU adder once per clock.
- Sits between the decode/execute stage and the ALU. It owns the ALU's a/b/cin/c2 inputs while busy, and it holds the HI/LO result pair until the next operation.
- Result is available to mfhi/mflo-style readers.

Parameters:
- bus, 8, operand width; HI and LO are each bus bits. Must be 2 or greater.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- op  input  1  0=MULTU, 1=DIVU (see Optional Feature)
- opa  input  bus  multiplicand / dividend
- opb  input  bus  multiplier / divisor
- alu_a  output  bus  ALU a operand
- alu_b  output  bus  ALU b operand
- alu_cin  output  1  ALU carry-in
- alu_c2  output  1  ALU complement-b select
- alu_sout  input  bus  ALU sum, combinational from alu_a/alu_b/alu_cin/alu_c2
- alu_cout  input  1  ALU carry-out
- busy  output  1  high while iterating
- done  output  1  one-cycle completion pulse
- hi  output  bus  product high half / remainder
- lo  output  bus  product low half / quotient
- res_zero  output  1  high when {hi,lo}==0

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- ALU contract: sout = a + (c2 ? ~b : b) + cin, truncated to bus bits; cout is the carry out of bit bus-1. The ALU is purely combinational, so each result is consumed in the same cycle.
- Reset: state=IDLE; busy=0; done=0; hi=0; lo=0; res_zero=1; iteration counter=0; alu_a/alu_b/alu_cin/alu_c2 all 0.
- Reset mid-operation: the same values apply on the next edge, and the operation is abandoned without a done pulse.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - ALU inputs are driven to 0.
  - start=1: latch opa/opb/op; set cnt=bus; go to RUN.
  - MULTU: hi=0, lo=opa, divisor/mcand reg M=opb.
  - DIVU: hi=0, lo=opa (dividend), M=opb.
- RUN: busy=1. One iteration per cycle; cnt decrements; on the cycle cnt==1 the next state is DONE. Exactly bus RUN cycles.
- MULTU iteration:
  - ALU drive: alu_a=hi, alu_b=(lo[0]?M:0), cin=0, c2=0.
  - Update: hi<={alu_cout, alu_sout[bus-1:1]}; lo<={alu_sout[0], lo[bus-1:1]}.
- DIVU iteration (restoring):
  - ALU drive: alu_a={hi[bus-2:0], lo[bus-1]}, alu_b=M, cin=1, c2=1.
  - ok = hi[bus-1] | alu_cout.
  - ok=1: hi<=alu_sout; lo<={lo[bus-2:0],1}.
  - ok=0: hi<=alu_a; lo<={lo[bus-2:0],0}.
- DONE: busy=0, done=1 for exactly this cycle; ALU inputs are driven to 0; next state is IDLE.
- Latency: start sampled at edge N, done high in the cycle after edge N+bus, result stable from that cycle.
- hi/lo hold their values in IDLE until the next accepted start.
- start while in RUN or DONE: ignored, not queued; opa/opb/op changes are also ignored.
- res_zero is derived combinationally from the hi/lo registers.
- Divide by zero (M=0): no special case. The algorithm yields lo=all ones and hi=dividend, and done timing is unchanged.
- Overflow/wrap: none. The 2*bus product always fits in {hi,lo}, and cout is captured into hi's MSB.

Optional Feature:
- Macro ALU_SEQ_DIV_EN.
- Defined: op=1 selects the DIVU iteration described above.
- Undefined:
  - The DIVU path is not built and op is ignored; every accepted start performs MULTU.
  - alu_cin and alu_c2 are tied to 0.
  - Port list is unchanged.

Test Plan:
- Reset: assert rst for 2 cycles with start=1 -> busy=0, done=0, hi=0x00, lo=0x00, res_zero=1, ALU outputs 0.
- MULTU, bus=8: opa=13, opb=11, start pulse -> busy for 8 cycles; done pulse on cycle 9 after start; hi=0x00, lo=0x8F, res_zero=0.
- MULTU carry path: opa=0xFF, opb=0xFF -> hi=0xFE, lo=0x01. A second start during RUN, with opa=1 and opb=1, is ignored, and the result is unchanged.
- DIVU (macro on): opa=200, opb=7 -> lo=0x1C, hi=0x04, 8 RUN cycles. Checker: each cycle, alu_c2=1 and alu_cin=1.
- DIVU by zero (macro on): opa=0x5A, opb=0 -> lo=0xFF, hi=0x5A, done at normal latency. Macro off: opa=200, opb=7, op=1 -> hi=0x05, lo=0x78 (1400).
- Reset mid-op: assert rst in the 4th RUN cycle of 13*11 -> no done pulse, hi=lo=0, IDLE. A new start then with 3*5 -> hi=0x00, lo=0x0F.
